// File: rtl/psram_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : psram_uart_pkg
// Purpose  : Shared constants and types for the UART-to-PSRAM command bridge:
//            opcode/response bytes, controller read_write codes, FSM states.
// Revision : 1.0  initial release
// ============================================================================
package psram_uart_pkg;

  // Command opcodes received from the UART
  localparam logic [7:0] c_OP_WRITE = 8'h57;  // 'W'
  localparam logic [7:0] c_OP_READ  = 8'h52;  // 'R'

  // Response bytes returned to the UART
  localparam logic [7:0] c_RSP_ACK  = 8'h4B;  // 'K'
  localparam logic [7:0] c_RSP_BAD  = 8'h3F;  // '?'
  localparam logic [7:0] c_RSP_ERR  = 8'h45;  // 'E'

  // Controller read_write codes
  localparam logic [1:0] RW_IDLE  = 2'd0;
  localparam logic [1:0] RW_WRITE = 2'd1;
  localparam logic [1:0] RW_READ  = 2'd2;

  // Bridge FSM states
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GET_ADDR = 3'd1,
    ST_GET_DATA = 3'd2,
    ST_ISSUE    = 3'd3,
    ST_WAIT_MEM = 3'd4,
    ST_SEND     = 3'd5
  } state_t;

endpackage : psram_uart_pkg
`default_nettype wire

// File: rtl/bridge_timer.sv
`default_nettype none
// ============================================================================
// Module   : bridge_timer
// Purpose  : Loadable down-counter. Counts down to zero after a load and
//            holds there; expired is high whenever the count is zero.
// Revision : 1.0  initial release
// ============================================================================
module bridge_timer #(
  parameter int WIDTH = 8
) (
  input  logic             mem_clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             expired
);

  logic [WIDTH-1:0] r_count;

  // Reload on request, otherwise count down and saturate at zero
  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_value;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign expired = (r_count == '0);

endmodule : bridge_timer
`default_nettype wire

// File: rtl/uart_psram_bridge.sv
`default_nettype none
// ============================================================================
// Module   : uart_psram_bridge
// Purpose  : Parses UART command frames ('W' A2 A1 A0 D1 D0 / 'R' A2 A1 A0)
//            into single-word PSRAM controller transactions and returns
//            read data or acknowledgement bytes to the UART transmitter.
// Revision : 1.0  initial release
// ============================================================================
module uart_psram_bridge
  import psram_uart_pkg::*;
#(
  parameter int FRAME_TIMEOUT = 84000,
  parameter int MEM_TIMEOUT   = 255
) (
  input  logic        mem_clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic        qpi_on,
  input  logic        endcommand,
  input  logic [15:0] data_out,
  output logic        quad_start,
  output logic [1:0]  read_write,
  output logic [22:0] address,
  output logic [15:0] data_in,
  output logic        busy,
  output logic        err_overrun
);

  localparam int c_FT_W = $clog2(FRAME_TIMEOUT + 1);
  localparam int c_MT_W = $clog2(MEM_TIMEOUT + 1);

  // Frame timer is reloaded on the accepting edge, so it expires at the
  // edge that closes the FRAME_TIMEOUT-th idle cycle.
  localparam logic [c_FT_W-1:0] c_FT_LOAD = c_FT_W'(FRAME_TIMEOUT - 1);
  // Memory timer is loaded at the end of the quad_start cycle.
  localparam logic [c_MT_W-1:0] c_MT_LOAD = c_MT_W'(MEM_TIMEOUT - 1);

  state_t      r_state;
  logic [2:0]  r_byte_cnt;
  logic        r_is_write;
  logic        r_second_pending;
  logic [7:0]  r_rd_lo;
  logic [7:0]  r_tx_data;
  logic        r_tx_valid;
  logic        r_quad_start;
  logic [1:0]  r_read_write;
  logic [22:0] r_address;
  logic [15:0] r_data_in;
  logic        r_busy;
  logic        r_err_overrun;

  logic        w_collecting;
  logic        w_frame_load;
  logic        w_frame_expired;
  logic        w_mem_expired;
  logic        w_rx_dropped;

  assign w_collecting = (r_state == ST_GET_ADDR) || (r_state == ST_GET_DATA);
  assign w_frame_load = rx_valid && (w_collecting || (r_state == ST_IDLE));
  assign w_rx_dropped = rx_valid && !w_collecting && (r_state != ST_IDLE);

  bridge_timer #(.WIDTH(c_FT_W)) u_frame_timer (
    .mem_clk    (mem_clk),
    .rst_n      (rst_n),
    .load       (w_frame_load),
    .load_value (c_FT_LOAD),
    .expired    (w_frame_expired)
  );

  bridge_timer #(.WIDTH(c_MT_W)) u_mem_timer (
    .mem_clk    (mem_clk),
    .rst_n      (rst_n),
    .load       (r_quad_start),
    .load_value (c_MT_LOAD),
    .expired    (w_mem_expired)
  );

  // Command FSM: frame parsing, controller handshake and response sequencing
  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= ST_IDLE;
      r_byte_cnt       <= 3'd0;
      r_is_write       <= 1'b0;
      r_second_pending <= 1'b0;
      r_rd_lo          <= 8'd0;
      r_tx_data        <= 8'd0;
      r_tx_valid       <= 1'b0;
      r_quad_start     <= 1'b0;
      r_read_write     <= RW_IDLE;
      r_address        <= 23'd0;
      r_data_in        <= 16'd0;
      r_busy           <= 1'b0;
      r_err_overrun    <= 1'b0;
    end else begin
      r_quad_start  <= 1'b0;
      r_err_overrun <= w_rx_dropped;

      case (r_state)
        ST_IDLE: begin
          if (rx_valid) begin
            r_busy <= 1'b1;
            if (rx_data == c_OP_WRITE || rx_data == c_OP_READ) begin
              r_is_write <= (rx_data == c_OP_WRITE);
              r_byte_cnt <= 3'd0;
              r_state    <= ST_GET_ADDR;
            end else begin
              r_tx_data        <= c_RSP_BAD;
              r_tx_valid       <= 1'b1;
              r_second_pending <= 1'b0;
              r_state          <= ST_SEND;
            end
          end
        end

        ST_GET_ADDR: begin
          if (rx_valid) begin
            case (r_byte_cnt)
              3'd0:    r_address[22:16] <= rx_data[6:0];
              3'd1:    r_address[15:8]  <= rx_data;
              default: r_address[7:0]   <= rx_data;
            endcase
            if (r_byte_cnt == 3'd2) begin
              r_byte_cnt <= 3'd0;
              if (r_is_write) begin
                r_state <= ST_GET_DATA;
              end else begin
                // Skip ISSUE when the controller is already up
                r_read_write <= RW_READ;
                r_quad_start <= qpi_on;
                r_state      <= qpi_on ? ST_WAIT_MEM : ST_ISSUE;
              end
            end else begin
              r_byte_cnt <= r_byte_cnt + 3'd1;
            end
          end else if (w_frame_expired) begin
            r_byte_cnt <= 3'd0;
            r_busy     <= 1'b0;
            r_state    <= ST_IDLE;
          end
        end

        ST_GET_DATA: begin
          if (rx_valid) begin
            if (r_byte_cnt == 3'd0) begin
              r_data_in[15:8] <= rx_data;
              r_byte_cnt      <= 3'd1;
            end else begin
              r_data_in[7:0] <= rx_data;
              r_byte_cnt     <= 3'd0;
              r_read_write   <= RW_WRITE;
              r_quad_start   <= qpi_on;
              r_state        <= qpi_on ? ST_WAIT_MEM : ST_ISSUE;
            end
          end else if (w_frame_expired) begin
            r_byte_cnt <= 3'd0;
            r_busy     <= 1'b0;
            r_state    <= ST_IDLE;
          end
        end

        ST_ISSUE: begin
          if (qpi_on) begin
            r_quad_start <= 1'b1;
            r_state      <= ST_WAIT_MEM;
          end
        end

        ST_WAIT_MEM: begin
          // endcommand seen during the quad_start cycle belongs to nothing
          if (!r_quad_start && endcommand) begin
            r_read_write <= RW_IDLE;
            r_tx_valid   <= 1'b1;
            r_state      <= ST_SEND;
            if (r_is_write) begin
              r_tx_data        <= c_RSP_ACK;
              r_second_pending <= 1'b0;
            end else begin
              r_tx_data        <= data_out[15:8];
              r_rd_lo          <= data_out[7:0];
              r_second_pending <= 1'b1;
            end
          end else if (!r_quad_start && w_mem_expired) begin
            r_read_write     <= RW_IDLE;
            r_tx_data        <= c_RSP_ERR;
            r_tx_valid       <= 1'b1;
            r_second_pending <= 1'b0;
            r_state          <= ST_SEND;
          end
        end

        ST_SEND: begin
          if (r_tx_valid && tx_ready) begin
            if (r_second_pending) begin
              r_tx_data        <= r_rd_lo;
              r_second_pending <= 1'b0;
            end else begin
              r_tx_valid <= 1'b0;
              r_busy     <= 1'b0;
              r_state    <= ST_IDLE;
            end
          end
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx_data     = r_tx_data;
  assign tx_valid    = r_tx_valid;
  assign quad_start  = r_quad_start;
  assign read_write  = r_read_write;
  assign address     = r_address;
  assign data_in     = r_data_in;
  assign busy        = r_busy;
  assign err_overrun = r_err_overrun;

endmodule : uart_psram_bridge
`default_nettype wire

// File: doc/uart_psram_bridge.md
# uart_psram_bridge

Command front-end for the PSRAM controller in the PSRAM_UART design. It parses a byte stream from the UART receiver into single-word PSRAM write and read transactions and drives the controller's `quad_start` / `read_write` / `address` / `data_in` handshake. It captures `data_out` on completion and returns read data or acknowledgements to the UART transmitter.

## Interface
Parameters:
- `FRAME_TIMEOUT`, 84000: max idle cycles between bytes of one frame (1 ms at 84 MHz).
- `MEM_TIMEOUT`, 255: max cycles from `quad_start` to `endcommand`.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-low. The clock port is `mem_clk`; the reset port is `rst_n`.
- `mem_clk` in 1: system/PSRAM clock; all logic on posedge.
- `rst_n` in 1: asynchronous active-low reset.
- `rx_data` in 8: received UART byte.
- `rx_valid` in 1: one-cycle strobe, `rx_data` valid.
- `tx_data` out 8: byte to transmit.
- `tx_valid` out 1: transmit request; held until `tx_ready`.
- `tx_ready` in 1: transmitter accepts `tx_data` this cycle.
- `qpi_on` in 1: controller initialised; no transaction issued while low.
- `endcommand` in 1: controller transaction finished.
- `data_out` in 16: controller read data.
- `quad_start` out 1: one-cycle transaction start pulse.
- `read_write` out 2: 2'd1 write, 2'd2 read, 2'd0 idle.
- `address` out 23: word address.
- `data_in` out 16: write data.
- `busy` out 1: high in any state except IDLE.
- `err_overrun` out 1: one-cycle pulse when an `rx_valid` byte is dropped.

## Operation
- Frame formats:
  - Write: 0x57 'W', A2, A1, A0, D1, D0. Address = {A2[6:0], A1, A0}; A2[7] is ignored. Data = {D1, D0}. Response 0x4B 'K'.
  - Read: 0x52 'R', A2, A1, A0. Response D1 then D0 (`data_out[15:8]` first).
  - Any other opcode byte in IDLE: response 0x3F '?', no memory access.
- States:
  - IDLE: on `rx_valid` decode the opcode; go to GET_ADDR, or to SEND with '?'.
  - GET_ADDR: collect 3 bytes MSB first; write goes to GET_DATA, read goes to ISSUE.
  - GET_DATA: collect 2 bytes, then go to ISSUE.
  - ISSUE: wait for `qpi_on`=1, then assert `quad_start` for exactly 1 cycle and go to WAIT_MEM.
  - WAIT_MEM: on `endcommand`=1 capture `data_out` and go to SEND. If `MEM_TIMEOUT` expires, send 0x45 'E'.
  - SEND: present the 1 or 2 response bytes on valid/ready, then go to IDLE.
- A 3-bit byte counter tracks position within GET_ADDR and GET_DATA.
- `address` and `data_in` update only while collecting. `read_write` is set when entering ISSUE, held through WAIT_MEM, and cleared to 0 on leaving WAIT_MEM.
- Frame timeout: in GET_ADDR or GET_DATA, if `FRAME_TIMEOUT` cycles pass with no `rx_valid`, discard the partial frame, go to IDLE, send no response.
  - The timer restarts on every accepted byte.
  - A timeout and an `rx_valid` in the same cycle: the byte wins.
- `rx_valid` in ISSUE, WAIT_MEM or SEND: the byte is dropped and `err_overrun` pulses. There is no buffering.

## Timing
- Reset values: `tx_data`=0, `tx_valid`=0, `quad_start`=0, `read_write`=0, `address`=0, `data_in`=0, `busy`=0, `err_overrun`=0; state IDLE; counters 0.
- Issue latency: last frame byte accepted at cycle t gives `quad_start`=1 at t+1 if `qpi_on` is high, otherwise the first cycle after `qpi_on` rises. `address`, `data_in` and `read_write` are stable from that cycle until WAIT_MEM exits.
- `endcommand` is ignored in the `quad_start` cycle. Completion is the first later posedge with `endcommand`=1.
- `MEM_TIMEOUT` counts cycles after the `quad_start` cycle.
- Response latency: `tx_valid`=1 the cycle after completion, and after `rx_valid` for a '?' response.
- Each response byte is held until the cycle of `tx_valid && tx_ready`. The second read byte is presented the next cycle.
- After the last handshake: IDLE, `busy`=0 on the following cycle. A new opcode is accepted from that cycle.
- Reset asserted mid-transaction forces all outputs to their reset values immediately; an in-flight PSRAM access is abandoned.

## Structure
- `psram_uart_pkg` holds:
  - opcode and response byte constants (0x57, 0x52, 0x4B, 0x3F, 0x45);
  - `read_write` codes RW_IDLE/RW_WRITE/RW_READ = 0/1/2;
  - the state enum.
- Sub-module `bridge_timer`: loadable down-counter with a `expired` flag, instantiated twice (frame timeout, memory timeout).
- Everything else stays in one FSM module.

## Test plan
- Write: W 00 12 34 AB CD → one `quad_start` pulse with `address`=0x001234, `data_in`=0xABCD, `read_write`=1; endcommand 10 cycles later → tx 0x4B.
- Read: R 80 00 05 with model `data_out`=0xBEEF → `address`=0x000005 (bit 7 of A2 dropped), `read_write`=2 → tx 0xBE then 0xEF. Hold `tx_ready` low 5 cycles and check `tx_data` stays stable.
- `qpi_on`=0 at end of frame → no `quad_start` until `qpi_on` rises; pulse the cycle after.
- Frame abort: W 00 12 then silence for `FRAME_TIMEOUT`+1 cycles → IDLE, no tx. A following valid R frame executes normally.
- Bad opcode and overrun: byte 0x41 → tx 0x3F. A byte sent during WAIT_MEM → `err_overrun` pulse and the transaction still completes.
- Memory timeout: `endcommand` never asserted → tx 0x45 after `MEM_TIMEOUT` cycles, `read_write` back to 0. Then assert `rst_n`=0 mid-frame → all outputs 0 asynchronously.
